fcn_layer_sequencer: RTL and testbench
======================================

FCN_LAYER_SEQUENCER -- requirements
Module: fcn_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3: number of chained FC layers sequenced.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: shared-BRAM data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12: shared-BRAM address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535: max cycles a layer may run before error.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk input 1 (rising edge); reset input 1 (synchronous, active-high).
REQ-006 SHALL have ports: i_start input 1, network run request; o_busy output 1, high while sequencing; o_done output 1, network-complete pulse; o_error output 1, sticky timeout flag.
REQ-007 SHALL have ports: o_layer_run output NUM_LAYERS, one-hot i_run pulses to layers; i_layer_done input NUM_LAYERS, layer_done from each layer.
REQ-008 SHALL have ports: o_active_layer output $clog2(NUM_LAYERS), current layer index; o_layer_cycles output 32, cycle count of last completed layer.
REQ-009 SHALL have requester ports: req_ce input NUM_LAYERS; req_we input NUM_LAYERS; req_addr input NUM_LAYERS*ADDR_WIDTH; req_din input NUM_LAYERS*DATA_WIDTH. Slice k belongs to layer k.
REQ-010 SHALL have shared-BRAM ports: bram_ce output 1, bram_we output 1, bram_addr output ADDR_WIDTH, bram_din output DATA_WIDTH.

Function
REQ-011 SHALL implement FSM S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_DONE, S_ERROR.
REQ-012 S_IDLE: i_start=1 -> S_LAUNCH next cycle, index cleared to 0, o_error cleared.
REQ-013 S_LAUNCH: o_layer_run[index]=1 for exactly one cycle, cycle counter cleared, -> S_WAIT.
REQ-014 S_WAIT: i_layer_done[index]=1 -> latch counter+1 into o_layer_cycles, -> S_NEXT; otherwise counter increments.
REQ-015 S_WAIT with timeout enabled: counter == TIMEOUT_CYCLES-1 and no done -> S_ERROR; done in that same cycle wins.
REQ-016 S_NEXT: index == NUM_LAYERS-1 -> S_DONE; else index+1 -> S_LAUNCH.
REQ-017 S_DONE: o_done=1 for one cycle, -> S_IDLE.
REQ-018 S_ERROR: o_error=1 held; -> S_IDLE next cycle with o_error still set until next accepted i_start.
REQ-019 o_busy SHALL be 1 in S_LAUNCH, S_WAIT, S_NEXT; 0 otherwise.
REQ-020 i_start outside S_IDLE SHALL be ignored; i_layer_done bits of non-active layers SHALL be ignored.
REQ-021 Port mux SHALL be combinational, zero latency: in S_LAUNCH/S_WAIT bram_* = requester slice [index]; else bram_ce=0, bram_we=0, bram_addr=0, bram_din=0.
REQ-022 Cycle counter SHALL saturate at 2^32-1.

Reset
REQ-023 On reset: state S_IDLE, index 0, counter 0, o_layer_cycles 0, o_busy 0, o_done 0, o_error 0, o_layer_run 0; bram_ce/we 0.
REQ-024 Reset asserted mid-sequence SHALL abort at the next edge with no o_done and no further o_layer_run pulse.

Configuration
REQ-025 Macro FCN_SEQ_TIMEOUT_EN: defined -> REQ-015/018 active; undefined -> S_WAIT waits indefinitely, S_ERROR unreachable, o_error tied 0.

Structure
REQ-026 fcn_pkg SHALL hold seq_state_e enum and the default TIMEOUT_CYCLES constant.
REQ-027 Port mux SHALL be sub-module fcn_bram_port_mux (parameterised NUM_LAYERS, DATA_WIDTH, ADDR_WIDTH, select input).

Verification (NUM_LAYERS=3, TIMEOUT_CYCLES=100, macro defined)
REQ-028 i_start at cycle 0; layers answer done 10, 20, 5 cycles after their run pulse -> run pulses on bits 0,1,2 in order; o_layer_cycles 10, 20, 5; single o_done; o_error 0.
REQ-029 Layer 1 never answers -> S_ERROR exactly 100 cycles after its run pulse; o_error=1; no o_done; bit 2 never pulsed.
REQ-030 Done on layer 1 while layer 0 active, plus i_start during S_WAIT -> both ignored; sequence and pulse count unchanged.
REQ-031 req_addr slice 1 = 0x0A5, req_we[1]=1 while layer 1 active -> bram_addr=0x0A5, bram_we=1 same cycle; in S_IDLE all bram_* = 0.
REQ-032 reset asserted in S_WAIT of layer 1 -> next cycle all outputs at reset values; following i_start restarts at layer 0.
REQ-033 Macro undefined, layer 0 done after 500 cycles -> no error; o_layer_cycles=500.

Source files
------------

// File: rtl/fcn_pkg.sv
// fcn_pkg: shared types and constants for the FC-layer sequencer.
//   seq_state_e        : sequencer FSM state encoding
//   TIMEOUT_CYCLES_DEF : default per-layer timeout in cycles
//   CNT_W              : width of the per-layer cycle counter
//   idx_width()        : width of a layer index (minimum 1 bit)
package fcn_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;
   localparam int unsigned CNT_W              = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_NEXT   = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } seq_state_e;

   // Index width for n layers; a single layer still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fcn_bram_port_mux.sv
// fcn_bram_port_mux: combinational selection of one layer's shared-BRAM
// request onto the single BRAM port.
//   i_en      : pass the selected requester through; otherwise drive zeros
//   i_sel     : index of the layer that owns the port
//   req_*     : packed per-layer request slices, slice k = layer k
//   bram_*    : shared BRAM port
module fcn_bram_port_mux
   import fcn_pkg::*;
#(
   parameter  int unsigned NUM_LAYERS = 3,
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned ADDR_WIDTH = 12,
   localparam int unsigned IDX_W      = idx_width(NUM_LAYERS)
) (
   input  logic                             i_en,
   input  logic [IDX_W-1:0]                 i_sel,
   input  logic [NUM_LAYERS-1:0]            req_ce,
   input  logic [NUM_LAYERS-1:0]            req_we,
   input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_LAYERS*DATA_WIDTH-1:0] req_din,
   output logic                             bram_ce,
   output logic                             bram_we,
   output logic [ADDR_WIDTH-1:0]            bram_addr,
   output logic [DATA_WIDTH-1:0]            bram_din
);

   // Zero-latency select; an idle port is fully quiet, not just ce-gated.
   always_comb begin
      bram_ce   = 1'b0;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_din  = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         if (i_en && (i_sel == IDX_W'(k))) begin
            bram_ce   = req_ce[k];
            bram_we   = req_we[k];
            bram_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            bram_din  = req_din[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/fcn_layer_sequencer.sv
// fcn_layer_sequencer: runs NUM_LAYERS chained FC layers one after another,
// hands the shared BRAM port to the active layer and times each layer.
// Optional feature: define FCN_SEQ_TIMEOUT_EN to abort a layer that runs
// for TIMEOUT_CYCLES without answering (sticky o_error); otherwise a layer
// may run indefinitely and o_error stays 0.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   i_start           : network run request (accepted only when idle)
//   o_busy / o_done   : sequencing in progress / network-complete pulse
//   o_error           : sticky timeout flag, cleared by the next accepted start
//   o_layer_run       : one-hot one-cycle run pulse to each layer
//   i_layer_done      : done from each layer (only the active bit is used)
//   o_active_layer    : current layer index
//   o_layer_cycles    : cycle count of the last completed layer
//   req_* / bram_*    : per-layer BRAM requests and the shared BRAM port
module fcn_layer_sequencer
   import fcn_pkg::*;
#(
   parameter  int unsigned NUM_LAYERS     = 3,
   parameter  int unsigned DATA_WIDTH     = 32,
   parameter  int unsigned ADDR_WIDTH     = 12,
   parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int unsigned IDX_W          = idx_width(NUM_LAYERS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_start,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_error,
   output logic [NUM_LAYERS-1:0]            o_layer_run,
   input  logic [NUM_LAYERS-1:0]            i_layer_done,
   output logic [IDX_W-1:0]                 o_active_layer,
   output logic [31:0]                      o_layer_cycles,
   input  logic [NUM_LAYERS-1:0]            req_ce,
   input  logic [NUM_LAYERS-1:0]            req_we,
   input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_LAYERS*DATA_WIDTH-1:0] req_din,
   output logic                             bram_ce,
   output logic                             bram_we,
   output logic [ADDR_WIDTH-1:0]            bram_addr,
   output logic [DATA_WIDTH-1:0]            bram_din
);

`ifdef FCN_SEQ_TIMEOUT_EN
   localparam logic TIMEOUT_EN = 1'b1;
`else
   localparam logic TIMEOUT_EN = 1'b0;
`endif

   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_LAYERS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cycles_q, cycles_d;
   logic [NUM_LAYERS-1:0] run_q, run_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  cur_done;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  mux_en;

   // Only the active layer's done bit matters; counter saturates.
   assign cur_done = i_layer_done[idx_q];
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         cycles_q <= '0;
         run_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         cycles_q <= cycles_d;
         run_q    <= run_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Next state, layer index and cycle counter.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      cycles_d = cycles_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_LAUNCH;
               idx_d   = '0;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done arriving on the last allowed cycle beats the timeout.
            if (cur_done) begin
               cycles_d = cnt_inc;
               state_d  = S_NEXT;
            end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_LAUNCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the next state so the registered copies line up
   // with the state they describe.
   always_comb begin
      run_d  = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
      err_d  = err_q;
      if (state_d == S_LAUNCH) begin
         run_d[idx_d] = 1'b1;
      end
      busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_NEXT);
      done_d = (state_d == S_DONE);
      if (state_d == S_ERROR) begin
         err_d = 1'b1;
      end else if ((state_q == S_IDLE) && (state_d == S_LAUNCH)) begin
         err_d = 1'b0;
      end
   end

   assign o_busy         = busy_q;
   assign o_done         = done_q;
   assign o_error        = TIMEOUT_EN & err_q;
   assign o_layer_run    = run_q;
   assign o_active_layer = idx_q;
   assign o_layer_cycles = cycles_q;

   // The active layer owns the BRAM from launch until it reports done.
   assign mux_en = (state_q == S_LAUNCH) || (state_q == S_WAIT);

   fcn_bram_port_mux #(
      .NUM_LAYERS (NUM_LAYERS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_port_mux (
      .i_en      (mux_en),
      .i_sel     (idx_q),
      .req_ce    (req_ce),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_din   (req_din),
      .bram_ce   (bram_ce),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din)
   );

endmodule

// File: tb/tb_fcn_layer_sequencer.sv
// Testbench for fcn_layer_sequencer: 3 layers, TIMEOUT_CYCLES = 100.
// A per-layer responder answers each run pulse after a programmed delay.
module tb_fcn_layer_sequencer;

   localparam int NL = 3;
   localparam int DW = 32;
   localparam int AW = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_start;
   logic              o_busy, o_done, o_error;
   logic [NL-1:0]     o_layer_run;
   logic [NL-1:0]     i_layer_done, resp_done, extra_done;
   logic [1:0]        o_active_layer;
   logic [31:0]       o_layer_cycles;
   logic [NL-1:0]     req_ce, req_we;
   logic [NL*AW-1:0]  req_addr;
   logic [NL*DW-1:0]  req_din;
   logic              bram_ce, bram_we;
   logic [AW-1:0]     bram_addr;
   logic [DW-1:0]     bram_din;

   always #5 clk = ~clk;

   assign i_layer_done = resp_done | extra_done;

   fcn_layer_sequencer #(
      .NUM_LAYERS(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .reset(reset), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
      .o_layer_run(o_layer_run), .i_layer_done(i_layer_done),
      .o_active_layer(o_active_layer), .o_layer_cycles(o_layer_cycles),
      .req_ce(req_ce), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
      .bram_ce(bram_ce), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic int now_cyc();
      return int'($time / 10);
   endfunction

   // Monitor + responder, evaluated on every falling edge.
   int          run_cnt[NL];
   int          run_t[NL];
   int          done_cnt, done_t, err_t, multi_hot;
   logic        err_prev;
   int          delay[NL];
   int          rem[NL];
   bit          pend_lc[NL];
   logic [31:0] lc_log[NL];

   initial begin
      done_cnt = 0; done_t = -1; err_t = -1; multi_hot = 0; err_prev = 1'b0;
      resp_done = '0;
      for (int k = 0; k < NL; k++) begin
         run_cnt[k] = 0; run_t[k] = -1; rem[k] = -1; pend_lc[k] = 0; lc_log[k] = '0;
      end
      forever begin
         @(negedge clk);
         if ($countones(o_layer_run) > 1) multi_hot++;
         for (int k = 0; k < NL; k++) begin
            if (o_layer_run[k]) begin run_cnt[k]++; run_t[k] = now_cyc(); end
         end
         if (o_done) begin done_cnt++; done_t = now_cyc(); end
         if (o_error && !err_prev) err_t = now_cyc();
         err_prev  = o_error;
         resp_done = '0;
         for (int k = 0; k < NL; k++) begin
            if (pend_lc[k]) begin lc_log[k] = o_layer_cycles; pend_lc[k] = 0; end
            if (reset) rem[k] = -1;
            else if (o_layer_run[k]) rem[k] = (delay[k] > 0) ? delay[k] : -1;
            else if (rem[k] > 0) begin
               rem[k]--;
               if (rem[k] == 0) begin
                  resp_done[k] = 1'b1; pend_lc[k] = 1; rem[k] = -1;
               end
            end
         end
      end
   end

   // Main sequence acts 2 time units after each falling edge.
   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #2; end
   endtask

   task automatic goto_cyc(input int c);
      int guard = 0;
      while (now_cyc() < c && guard < 20000) begin @(negedge clk); #2; guard++; end
      if (guard >= 20000) begin
         n_total++;
         $display("FAIL goto_cyc: reached %0d, required %0d", now_cyc(), c);
      end
   endtask

   task automatic pulse_start(output int s);
      s = now_cyc();
      i_start = 1'b1;
      step(1);
      i_start = 1'b0;
   endtask

   task automatic set_delays(input int a, input int b, input int c);
      delay[0] = a; delay[1] = b; delay[2] = c;
   endtask

   typedef struct {
      int d0, d1, d2;
      int p1, p2, dn;
      int lc0, lc1, lc2;
   } vec_t;

   vec_t vecs[4];

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, now at cycle %0d", now_cyc());
      $fatal(1, "watchdog");
   end

   initial begin : main
      int s, t;
      int r0, r1, r2, dc;

      // delays; expected run-pulse 1/2 and done offsets from start cycle; latched counts
      vecs[0] = '{d0:10,  d1:20, d2:5, p1:13,  p2:35,  dn:42,  lc0:10,  lc1:20, lc2:5};
      vecs[1] = '{d0:1,   d1:1,  d2:1, p1:4,   p2:7,   dn:10,  lc0:1,   lc1:1,  lc2:1};
      vecs[2] = '{d0:3,   d1:7,  d2:2, p1:6,   p2:15,  dn:19,  lc0:3,   lc1:7,  lc2:2};
      vecs[3] = '{d0:100, d1:2,  d2:1, p1:103, p2:107, dn:110, lc0:100, lc1:2,  lc2:1};

      reset = 1'b1; i_start = 1'b0; extra_done = '0;
      set_delays(0, 0, 0);
      req_ce   = 3'b111;
      req_we   = 3'b010;
      req_addr = {12'h222, 12'h0A5, 12'h111};
      req_din  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      step(3);
      check("rst_busy",   o_busy, 0);
      check("rst_done",   o_done, 0);
      check("rst_error",  o_error, 0);
      check("rst_run",    o_layer_run, 0);
      check("rst_cycles", o_layer_cycles, 0);
      check("rst_active", o_active_layer, 0);
      check("rst_bram_ce", bram_ce, 0);
      check("rst_bram_we", bram_we, 0);
      reset = 1'b0;
      step(2);

      // Table-driven complete network runs.
      for (int i = 0; i < 4; i++) begin
         set_delays(vecs[i].d0, vecs[i].d1, vecs[i].d2);
         r0 = run_cnt[0]; r1 = run_cnt[1]; r2 = run_cnt[2]; dc = done_cnt;
         pulse_start(s);
         goto_cyc(s + vecs[i].dn + 2);
         check($sformatf("v%0d_p0", i), run_t[0] - s, 1);
         check($sformatf("v%0d_p1", i), run_t[1] - s, vecs[i].p1);
         check($sformatf("v%0d_p2", i), run_t[2] - s, vecs[i].p2);
         check($sformatf("v%0d_done_t", i), done_t - s, vecs[i].dn);
         check($sformatf("v%0d_lc0", i), lc_log[0], vecs[i].lc0);
         check($sformatf("v%0d_lc1", i), lc_log[1], vecs[i].lc1);
         check($sformatf("v%0d_lc2", i), lc_log[2], vecs[i].lc2);
         check($sformatf("v%0d_runs", i),
               (run_cnt[0]-r0)*100 + (run_cnt[1]-r1)*10 + (run_cnt[2]-r2), 111);
         check($sformatf("v%0d_ndone", i), done_cnt - dc, 1);
         check($sformatf("v%0d_err", i), o_error, 0);
         check($sformatf("v%0d_busy", i), o_busy, 0);
      end

      // Stray done / stray start while layer 0 runs; BRAM port mux.
      set_delays(10, 20, 5);
      r0 = run_cnt[0]; r1 = run_cnt[1]; r2 = run_cnt[2]; dc = done_cnt;
      pulse_start(s);
      goto_cyc(s + 4);
      check("mux0_ce",   bram_ce, 1);
      check("mux0_we",   bram_we, 0);
      check("mux0_addr", bram_addr, 12'h111);
      check("mux0_din",  bram_din, 32'hAAAA_0000);
      extra_done = 3'b010;
      i_start    = 1'b1;
      step(1);
      extra_done = '0;
      i_start    = 1'b0;
      goto_cyc(s + 20);
      check("mux1_active", o_active_layer, 1);
      check("mux1_ce",   bram_ce, 1);
      check("mux1_we",   bram_we, 1);
      check("mux1_addr", bram_addr, 12'h0A5);
      check("mux1_din",  bram_din, 32'hBBBB_0001);
      req_addr[23:12] = 12'h0B6;
      #1;
      check("mux1_addr_live", bram_addr, 12'h0B6);
      req_addr[23:12] = 12'h0A5;
      goto_cyc(s + 44);
      check("ign_p1", run_t[1] - s, 13);
      check("ign_p2", run_t[2] - s, 35);
      check("ign_done_t", done_t - s, 42);
      check("ign_lc0", lc_log[0], 10);
      check("ign_runs", (run_cnt[0]-r0)*100 + (run_cnt[1]-r1)*10 + (run_cnt[2]-r2), 111);
      check("ign_ndone", done_cnt - dc, 1);
      check("idle_bram_ce",   bram_ce, 0);
      check("idle_bram_we",   bram_we, 0);
      check("idle_bram_addr", bram_addr, 0);
      check("idle_bram_din",  bram_din, 0);

`ifdef FCN_SEQ_TIMEOUT_EN
      // Layer 1 never answers: error after its 100th waiting cycle.
      set_delays(10, 0, 5);
      r1 = run_cnt[1]; r2 = run_cnt[2]; dc = done_cnt;
      pulse_start(s);
      goto_cyc(s + 113);
      check("to_err_before", o_error, 0);
      check("to_busy_before", o_busy, 1);
      step(1);
      check("to_err_t", err_t - s, 114);
      check("to_err", o_error, 1);
      check("to_busy", o_busy, 0);
      goto_cyc(s + 117);
      check("to_err_sticky", o_error, 1);
      check("to_no_p2", run_cnt[2] - r2, 0);
      check("to_p1", run_cnt[1] - r1, 1);
      check("to_no_done", done_cnt - dc, 0);
      set_delays(1, 1, 1);
      dc = done_cnt;
      pulse_start(t);
      check("to_err_clear", o_error, 0);
      goto_cyc(t + 12);
      check("to_rerun_done", done_cnt - dc, 1);
`else
      // Without the timeout a long layer simply completes.
      set_delays(500, 1, 1);
      dc = done_cnt;
      pulse_start(s);
      goto_cyc(s + 511);
      check("nto_lc0", lc_log[0], 500);
      check("nto_err", o_error, 0);
      check("nto_done_t", done_t - s, 509);
      check("nto_ndone", done_cnt - dc, 1);
`endif

      // Reset during layer 1 wait aborts the run.
      set_delays(4, 0, 3);
      r0 = run_cnt[0]; r1 = run_cnt[1]; r2 = run_cnt[2]; dc = done_cnt;
      pulse_start(s);
      goto_cyc(s + 10);
      check("mr_active", o_active_layer, 1);
      check("mr_busy", o_busy, 1);
      reset = 1'b1;
      step(1);
      check("mr_busy0",   o_busy, 0);
      check("mr_done0",   o_done, 0);
      check("mr_err0",    o_error, 0);
      check("mr_run0",    o_layer_run, 0);
      check("mr_active0", o_active_layer, 0);
      check("mr_cycles0", o_layer_cycles, 0);
      check("mr_bram_ce", bram_ce, 0);
      check("mr_bram_we", bram_we, 0);
      check("mr_bram_addr", bram_addr, 0);
      reset = 1'b0;
      goto_cyc(s + 40);
      check("mr_runs", (run_cnt[0]-r0)*100 + (run_cnt[1]-r1)*10 + (run_cnt[2]-r2), 110);
      check("mr_no_done", done_cnt - dc, 0);
      set_delays(2, 2, 2);
      dc = done_cnt;
      pulse_start(t);
      check("mr_restart_run", o_layer_run, 3'b001);
      goto_cyc(t + 15);
      check("mr_restart_done_t", done_t - t, 13);
      check("mr_restart_ndone", done_cnt - dc, 1);

      check("onehot_runs", multi_hot, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
